// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and halt sequencer for the 5-stage pipeline.
//
// Each cycle it picks the fetch next-PC source, decides whether the PC and IF/ID
// hold, and decides whether IF/ID or ID/EX take a NOP. When the halt word is
// fetched, it drains EX/MEM/WB and then parks in HALT. It also keeps
// cycle, stall and redirect performance counters.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   id_rs, id_rt        source register fields of the instruction in ID
//   id_uses_rt          ID instruction reads rt
//   id_jump, id_jr      J/JAL or JR in ID
//   ex_mem_read, ex_rt  load in EX and its destination register
//   ex_branch_taken     branch in EX resolved taken
//   if_halt_seen        fetched word is the halt word
//   pc_source           00 PC+1, 01 branch, 10 JR register, 11 jump target
//   pc_stall            hold PC and IF/ID
//   flush_if_id         load NOP into IF/ID
//   bubble_id_ex        load NOP into ID/EX
//   halted              pipeline drained (sticky until reset)
//   cycle_count, stall_count, redirect_count  performance counters
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        id_jump,
    input  logic        id_jr,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        ex_branch_taken,
    input  logic        if_halt_seen,
    output logic [1:0]  pc_source,
    output logic        pc_stall,
    output logic        flush_if_id,
    output logic        bubble_id_ex,
    output logic        halted,
    output logic [31:0] cycle_count,
    output logic [31:0] stall_count,
    output logic [31:0] redirect_count
);

    // The drain counter only has to hold DRAIN_CYCLES-1.
    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] DRAIN_LOAD = (DRAIN_CYCLES > 0) ? CW'(DRAIN_CYCLES - 1) : '0;

    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

    state_t        state, next_state;
    logic [CW-1:0] drain_cnt, next_cnt;
    logic [31:0]   cyc_q, stl_q, red_q;
    logic          inc_stall, inc_redir;
    logic          lu;

    assign lu = ex_mem_read && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        next_state   = state;
        next_cnt     = drain_cnt;
        inc_stall    = 1'b0;
        inc_redir    = 1'b0;
        pc_source    = 2'b00;
        pc_stall     = 1'b0;
        flush_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        halted       = 1'b0;
        case (state)
            RUN: begin
                if (ex_branch_taken) begin
                    // Any halt fetched alongside is wrong-path and gets flushed.
                    pc_source    = 2'b01;
                    flush_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                    inc_redir    = 1'b1;
                end else if (lu) begin
                    // A jump/JR in ID is deferred. It is still in ID next cycle.
                    pc_stall     = 1'b1;
                    bubble_id_ex = 1'b1;
                    inc_stall    = 1'b1;
                end else if (id_jr) begin
                    pc_source   = 2'b10;
                    flush_if_id = 1'b1;
                    inc_redir   = 1'b1;
                end else if (id_jump) begin
                    pc_source   = 2'b11;
                    flush_if_id = 1'b1;
                    inc_redir   = 1'b1;
                end else if (if_halt_seen) begin
                    pc_stall    = 1'b1;
                    flush_if_id = 1'b1;
                    if (DRAIN_CYCLES == 0) begin
                        next_state = HALT;
                    end else begin
                        next_state = DRAIN;
                        next_cnt   = DRAIN_LOAD;
                    end
                end
            end
            DRAIN: begin
                flush_if_id = 1'b1;
                if (ex_branch_taken) begin
                    // An older branch resolved taken, so the halt was wrong-path.
                    pc_source    = 2'b01;
                    bubble_id_ex = 1'b1;
                    inc_redir    = 1'b1;
                    next_state   = RUN;
                    next_cnt     = '0;
                end else begin
                    pc_stall = 1'b1;
                    if (drain_cnt == '0) next_state = HALT;
                    else                 next_cnt   = drain_cnt - CW'(1);
                end
            end
            HALT: begin
                pc_stall     = 1'b1;
                flush_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
                halted       = 1'b1;
            end
            default: next_state = RUN;
        endcase
        // A reset cycle presents all-zero outputs, whatever the state and inputs are.
        if (reset) begin
            pc_source    = 2'b00;
            pc_stall     = 1'b0;
            flush_if_id  = 1'b0;
            bubble_id_ex = 1'b0;
            halted       = 1'b0;
        end
    end

    assign cycle_count    = reset ? 32'd0 : cyc_q;
    assign stall_count    = reset ? 32'd0 : stl_q;
    assign redirect_count = reset ? 32'd0 : red_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= '0;
            cyc_q     <= '0;
            stl_q     <= '0;
            red_q     <= '0;
        end else begin
            state     <= next_state;
            drain_cnt <= next_cnt;
            if (state != HALT) cyc_q <= cyc_q + 32'd1;
            if (inc_stall)     stl_q <= stl_q + 32'd1;
            if (inc_redir)     red_q <= red_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed-vector bench for pipeline_ctrl. The driver applies one vector per
// cycle and queues its hand-computed expected outputs. The monitor pops and
// compares in the middle of each cycle.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        id_uses_rt, id_jump, id_jr, ex_mem_read, ex_branch_taken, if_halt_seen;
    logic [1:0]  pc_source;
    logic        pc_stall, flush_if_id, bubble_id_ex, halted;
    logic [31:0] cycle_count, stall_count, redirect_count;

    pipeline_ctrl #(.DRAIN_CYCLES(3)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_jump(id_jump), .id_jr(id_jr),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
        .ex_branch_taken(ex_branch_taken), .if_halt_seen(if_halt_seen),
        .pc_source(pc_source), .pc_stall(pc_stall), .flush_if_id(flush_if_id),
        .bubble_id_ex(bubble_id_ex), .halted(halted),
        .cycle_count(cycle_count), .stall_count(stall_count),
        .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    // ctrl packs {pc_source, pc_stall, flush_if_id, bubble_id_ex, halted}
    typedef struct {
        int          idx;
        logic [5:0]  ctrl;
        logic [31:0] cyc, stl, red;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   vec   = 0;
    bit   done  = 1'b0;

    task automatic step(
        input logic       rst,
        input logic [4:0] rs, input logic [4:0] rt, input logic urt,
        input logic jmp, input logic jr,
        input logic mr, input logic [4:0] xrt, input logic bt, input logic hlt,
        input logic [5:0] e_ctrl, input int e_cyc, input int e_stl, input int e_red);
        exp_t e;
        @(posedge clk); #1;
        reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        id_jump = jmp; id_jr = jr; ex_mem_read = mr; ex_rt = xrt;
        ex_branch_taken = bt; if_halt_seen = hlt;
        e.idx = vec; e.ctrl = e_ctrl;
        e.cyc = e_cyc; e.stl = e_stl; e.red = e_red;
        exp_q.push_back(e);
        vec++;
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL vec%0d %s: got %h want %h", idx, name, act, req);
        end
    endtask

    // Monitor: these outputs are valid every cycle, so one queued expectation is consumed per cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ctrl", e.idx, {26'd0, pc_source, pc_stall, flush_if_id, bubble_id_ex, halted}, {26'd0, e.ctrl});
            check("cycle_count", e.idx, cycle_count, e.cyc);
            check("stall_count", e.idx, stall_count, e.stl);
            check("redirect_count", e.idx, redirect_count, e.red);
        end
    end

    // ctrl shorthands
    localparam logic [5:0] C_IDLE  = 6'b00_0000;
    localparam logic [5:0] C_LU    = 6'b00_1010;
    localparam logic [5:0] C_BR    = 6'b01_0110;
    localparam logic [5:0] C_JR    = 6'b10_0100;
    localparam logic [5:0] C_JMP   = 6'b11_0100;
    localparam logic [5:0] C_HOLD  = 6'b00_1100;
    localparam logic [5:0] C_HALT  = 6'b00_1111;

    initial begin
        reset = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_jump = 1'b0;
        id_jr = 1'b0; ex_mem_read = 1'b0; ex_rt = '0; ex_branch_taken = 1'b0; if_halt_seen = 1'b0;
        //   rst rs  rt  urt jmp jr  mr  xrt bt  hlt   ctrl     cyc stl red
        step(1, 5,  0,  0,  0,  0,  1,  5,  0,  1,   C_IDLE,  0,  0,  0);  // reset with lu+halt
        step(0, 0,  0,  0,  0,  0,  0,  0,  0,  0,   C_IDLE,  0,  0,  0);
        step(0, 0,  0,  0,  0,  0,  0,  0,  0,  0,   C_IDLE,  1,  0,  0);
        step(0, 5,  0,  0,  0,  0,  1,  5,  0,  0,   C_LU,    2,  0,  0);  // load-use on rs
        step(0, 5,  0,  0,  0,  0,  1,  5,  0,  0,   C_LU,    3,  1,  0);  // repeat stalls again
        step(0, 0,  0,  0,  0,  0,  1,  0,  0,  0,   C_IDLE,  4,  2,  0);  // ex_rt==0
        step(0, 3,  5,  0,  0,  0,  1,  5,  0,  0,   C_IDLE,  5,  2,  0);  // rt match, rt unused
        step(0, 3,  5,  1,  0,  0,  1,  5,  0,  0,   C_LU,    6,  2,  0);  // rt match, rt used
        step(0, 5,  0,  0,  1,  0,  1,  5,  1,  0,   C_BR,    7,  3,  0);  // branch beats lu+jump
        step(0, 5,  0,  0,  0,  1,  1,  5,  0,  0,   C_LU,    8,  3,  1);  // lu defers jr
        step(0, 0,  0,  0,  0,  1,  0,  0,  0,  0,   C_JR,    9,  4,  1);
        step(0, 0,  0,  0,  1,  0,  0,  0,  0,  0,   C_JMP,  10,  4,  2);
        step(0, 0,  0,  0,  1,  0,  0,  0,  0,  1,   C_JMP,  11,  4,  3);  // halt ignored under jump
        step(0, 5,  0,  0,  0,  0,  1,  5,  0,  1,   C_LU,   12,  4,  4);  // halt not accepted under lu
        step(0, 0,  0,  0,  0,  0,  0,  0,  1,  1,   C_BR,   13,  5,  4);  // halt ignored under branch
        step(0, 0,  0,  0,  0,  0,  0,  0,  0,  1,   C_HOLD, 14,  5,  5);  // halt accepted (t)
        step(0, 5,  0,  0,  1,  0,  1,  5,  0,  0,   C_HOLD, 15,  5,  5);  // drain ignores lu/jump
        step(0, 0,  0,  0,  0,  0,  0,  0,  0,  0,   C_HOLD, 16,  5,  5);
        step(0, 0,  0,  0,  0,  0,  0,  0,  0,  0,   C_HOLD, 17,  5,  5);  // t+3 still draining
        step(0, 0,  0,  0,  0,  0,  0,  0,  0,  0,   C_HALT, 18,  5,  5);  // t+4 halted
        step(0, 0,  0,  0,  1,  0,  0,  0,  1,  0,   C_HALT, 18,  5,  5);  // sticky, frozen
        step(0, 0,  0,  0,  0,  0,  0,  0,  0,  0,   C_HALT, 18,  5,  5);
        step(1, 0,  0,  0,  1,  0,  0,  0,  1,  0,   C_IDLE,  0,  0,  0);  // reset in HALT
        step(0, 0,  0,  0,  0,  0,  0,  0,  0,  0,   C_IDLE,  0,  0,  0);
        step(0, 0,  0,  0,  0,  0,  0,  0,  0,  1,   C_HOLD,  1,  0,  0);  // halt accepted
        step(0, 0,  0,  0,  0,  0,  0,  0,  1,  0,   C_BR,    2,  0,  0);  // abort at t+1
        step(0, 0,  0,  0,  0,  0,  0,  0,  0,  0,   C_IDLE,  3,  0,  1);  // back in RUN
        step(0, 0,  0,  0,  0,  0,  0,  0,  0,  1,   C_HOLD,  4,  0,  1);
        step(0, 0,  0,  0,  0,  0,  0,  0,  0,  0,   C_HOLD,  5,  0,  1);
        step(0, 0,  0,  0,  0,  0,  0,  0,  1,  0,   C_BR,    6,  0,  1);  // abort at t+2
        step(0, 0,  0,  0,  0,  0,  0,  0,  0,  0,   C_IDLE,  7,  0,  2);
        step(0, 0,  0,  0,  0,  0,  0,  0,  0,  1,   C_HOLD,  8,  0,  2);
        step(1, 0,  0,  0,  0,  0,  0,  0,  0,  0,   C_IDLE,  0,  0,  0);  // reset mid-drain
        step(0, 0,  0,  0,  0,  0,  0,  0,  0,  0,   C_IDLE,  0,  0,  0);
        step(0, 0,  0,  0,  0,  0,  0,  0,  0,  0,   C_IDLE,  1,  0,  0);
        done = 1'b1;
    end

    initial begin
        fork
            wait (done && exp_q.size() == 0);
            begin
                repeat (200) @(posedge clk);
                total++;
                bad++;
                $display("FAIL timeout: pending=%0d want 0", exp_q.size());
            end
        join_any
        disable fork;
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and halt sequencer for the 5-stage pipeline. It sits beside the fetch stage and decides every cycle:
- which next-PC source the fetch mux selects;
- whether the PC and the IF/ID latch hold;
- whether IF/ID or ID/EX receive a NOP.

It also drains the pipeline cleanly when the halt word (32'hffffffff) is fetched, and keeps cycle/stall/redirect performance counters.

## Interface
- DRAIN_CYCLES, 3, cycles after halt acceptance until `halted` rises (EX, MEM, WB retire)
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- id_jump  in  1  J/JAL in ID
- id_jr  in  1  JR in ID
- ex_mem_read  in  1  load in EX
- ex_rt  in  5  destination of load in EX
- ex_branch_taken  in  1  branch in EX resolved taken
- if_halt_seen  in  1  fetched word == 32'hffffffff
- pc_source  out  2  00 PC+1, 01 branch target, 10 register target (JR), 11 jump target
- pc_stall  out  1  hold PC and IF/ID
- flush_if_id  out  1  load NOP into IF/ID
- bubble_id_ex  out  1  load NOP into ID/EX
- halted  out  1  pipeline drained, sticky
- cycle_count  out  32  cycles since reset
- stall_count  out  32  load-use stall cycles
- redirect_count  out  32  accepted branch/jump redirects

## Operation
States are RUN, DRAIN, HALT. `reset` forces RUN, drain counter 0, all counters 0.

**Load-use detection (`lu`):** `ex_mem_read && ex_rt!=0 && (ex_rt==id_rs || (id_uses_rt && ex_rt==id_rt))`.

**RUN** — first matching rule wins:
1. `ex_branch_taken`:
   - pc_source=01, flush_if_id=1, bubble_id_ex=1.
   - redirect_count+1.
   - Any halt seen this cycle is wrong-path and is ignored.
2. `lu`:
   - pc_stall=1, bubble_id_ex=1, pc_source=00.
   - stall_count+1.
   - A jump or JR in ID is deferred; a halt seen this cycle is not accepted.
3. `id_jr`:
   - pc_source=10, flush_if_id=1.
   - redirect_count+1.
   - A halt seen this cycle is ignored.
4. `id_jump`:
   - pc_source=11, flush_if_id=1.
   - redirect_count+1.
   - A halt seen this cycle is ignored.
5. `if_halt_seen` (accept):
   - pc_stall=1, flush_if_id=1.
   - Load drain counter with DRAIN_CYCLES-1; go to DRAIN.
   - If DRAIN_CYCLES==0, go directly to HALT.
6. Otherwise: pc_source=00, all controls 0.

**DRAIN**
- pc_stall=1, flush_if_id=1, pc_source=00.
- `ex_branch_taken` aborts the drain because the halt was wrong-path:
  - pc_source=01, pc_stall=0, flush_if_id=1, bubble_id_ex=1.
  - redirect_count+1; return to RUN; drain counter cleared.
- Otherwise the counter decrements; when it reaches 0, go to HALT.
- `lu`, `id_jump`, `id_jr` are ignored (ID holds a NOP).

**HALT**
- pc_stall=1, flush_if_id=1, bubble_id_ex=1, halted=1, pc_source=00.
- All inputs are ignored; only `reset` leaves this state.

**Counters**
- cycle_count increments every non-reset cycle in RUN and DRAIN; it freezes in HALT.
- All counters wrap modulo 2^32.
- Counter increments and state updates happen at the clock edge ending the cycle in which the condition holds.

## Timing
- Control outputs are combinational from the current state and inputs; zero latency, valid in the same cycle.
- During a reset cycle every output is 0 and pc_source=00, regardless of inputs.
- Load-use stall lasts exactly one cycle per hazard. A repeat in the next cycle (new load in EX) stalls again.
- Halt to `halted`: if_halt_seen accepted in cycle t gives halted=1 from cycle t+1+DRAIN_CYCLES (default t+4).
- A drain abort by `ex_branch_taken` is possible in any DRAIN cycle.
- Reset mid-DRAIN or in HALT: RUN the next cycle, counters 0.

## Test plan
- **Reset:**
  - Stimulus: reset=1 with `lu` and `if_halt_seen` true.
  - Required: all outputs 0, pc_source=00; the cycle after release, cycle_count=0, then 1.
- **Load-use:**
  - Stimulus: ex_mem_read=1, ex_rt=5, id_rs=5 for one cycle.
  - Required: pc_stall=1, bubble_id_ex=1, stall_count=1.
  - Repeat with ex_rt=0: no stall.
  - Repeat with id_uses_rt=0 and id_rt=5: no stall.
- **Priority:**
  - Stimulus: ex_branch_taken, `lu` and id_jump all high.
  - Required: pc_source=01, flush=1, bubble=1, pc_stall=0, redirect_count+1, stall_count unchanged.
  - Stimulus: `lu` and id_jr high.
  - Required: stall only; next cycle with `lu` low gives pc_source=10.
- **Halt drain:**
  - Stimulus: if_halt_seen=1 at cycle t, DRAIN_CYCLES=3.
  - Required: pc_stall=1 from t; halted=0 through t+3, halted=1 at t+4; cycle_count frozen thereafter.
- **Drain abort:**
  - Stimulus: halt accepted at t, ex_branch_taken=1 at t+1.
  - Required: pc_source=01, pc_stall=0, state RUN at t+2, halted stays 0.
- **Sticky halt / reset:**
  - Stimulus: in HALT, pulse id_jump and ex_branch_taken.
  - Required: outputs unchanged.
  - Stimulus: assert reset.
  - Required: RUN and counters 0 on the next cycle.
